noc_router: RTL and testbench
=============================

NOC_ROUTER -- requirements
Module: noc_router

Interface
REQ-001 Parameter ADDR_X, 0, column coordinate of this router.
REQ-002 Parameter ADDR_Y, 0, row coordinate of this router.
REQ-003 Parameter COLS, 4, mesh width used for destination range check.
REQ-004 Parameter ROWS, 4, mesh height used for destination range check.
REQ-005 Parameter DATA_WIDTH, 32, flit width.
REQ-006 Parameter ADDR_W, 4, width of each destination coordinate field.
REQ-007 Parameter FIFO_DEPTH, 4, per-input FIFO entries; power of two, >=2.
REQ-008 Parameter CNT_W, 16, drop counter width.
REQ-009 clk  input  1  sole clock; all state updates on rising edge.
REQ-010 rst  input  1  reset, synchronous, active-high.
REQ-011 din  input  5*DATA_WIDTH  input flits; port p at bits [p*DATA_WIDTH +: DATA_WIDTH].
REQ-012 vin  input  5  input valid per port.
REQ-013 rout  output  5  input ready per port.
REQ-014 dout  output  5*DATA_WIDTH  output flits, same slicing as din.
REQ-015 vout  output  5  output valid per port.
REQ-016 rin  input  5  downstream ready per output port.
REQ-017 drop_count  output  CNT_W  count of flits discarded for out-of-range destination.
REQ-018 Port index SHALL be 0 local, 1 north (y-1), 2 east (x+1), 3 south (y+1), 4 west (x-1).

Function
REQ-019 Flits SHALL be single-flit packets; dest_x = din[DATA_WIDTH-1 -: ADDR_W], dest_y = the next ADDR_W bits below it.
REQ-020 Input handshake: transfer when vin[p] & rout[p] at a clock edge; rout[p] = !full of FIFO p (registered-state only, no combinational path from vin/rin).
REQ-021 Write to a full FIFO SHALL never occur; simultaneous read and write on a non-full FIFO SHALL keep occupancy unchanged.
REQ-022 Route of FIFO head: dest_x > ADDR_X -> east; < -> west; else dest_y > ADDR_Y -> south; < -> north; else local.
REQ-023 Head with dest_x >= COLS or dest_y >= ROWS SHALL be popped without output, incrementing drop_count by 1 that cycle.
REQ-024 drop_count SHALL saturate at all-ones, not wrap.
REQ-025 Each output SHALL have a round-robin arbiter over the 5 inputs whose head routes to it; priority starts at the input after the last granted one.
REQ-026 With no grant in a cycle an arbiter's pointer SHALL hold.
REQ-027 Each output SHALL have one output register; it loads the granted flit when empty or when being drained that cycle (vout & rin), giving one flit per cycle per output.
REQ-028 Output transfer when vout[q] & rin[q]; while vout[q] & !rin[q], dout[q] and vout[q] SHALL hold stable.
REQ-029 A granted head SHALL be popped in the same cycle its flit is loaded into the output register.
REQ-030 Minimum latency: flit accepted at edge N SHALL show vout at cycle following edge N+1 (2 cycles).
REQ-031 Distinct outputs SHALL be served in parallel in the same cycle; one input feeds at most one output per cycle.
REQ-032 Flits from one input to one output SHALL leave in arrival order.
REQ-033 rin held low on an edge output (e.g. north at ADDR_Y=0) SHALL only back-pressure; no flit is lost.

Reset
REQ-034 With rst high at an edge: all FIFOs empty, all vout 0, dout 0, arbiter pointers 0, drop_count 0.
REQ-035 After reset rout SHALL be all ones.
REQ-036 Reset mid-operation SHALL discard all buffered and in-register flits in that cycle; vin ignored while rst high.

Verification
REQ-037 Router (1,1), local injects 0x2100_0000 (dest x=2,y=1), rin all 1 -> east vout high 2 cycles later with same data; other vout 0.
REQ-038 North, west and local inputs all send to east each cycle, rin[2]=1 -> east output grants rotate north, west, local... ; each input gets 1/3 of slots, no starvation.
REQ-039 rin[2]=0, local sends 6 flits to east, FIFO_DEPTH=4 -> 4 buffered + 1 in output register, rout[0] low after 5th accept; release rin -> all 6 out in order.
REQ-040 Local injects dest x=7,y=0 with COLS=4 -> no vout anywhere, drop_count 0 -> 1; repeat at all-ones -> stays all-ones.
REQ-041 Simultaneous flits north->south and west->east -> both delivered in same cycle, latency 2.
REQ-042 Assert rst for 1 cycle with 3 flits buffered -> next cycle all vout 0, rout all 1, drop_count 0; no stale flit emitted afterwards.

Source files
------------

// File: rtl/noc_router.sv
// Small synchronous FIFO used as the per-input buffer of the router.
// Latency: a written entry is visible at the head on the cycle after the write.
// Backpressure: full is pure register state; writes while full are ignored.
module noc_router_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_en,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    // DEPTH is a power of two, so the count MSB alone marks full.
    assign full     = count[AW];
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];
    assign do_wr    = wr_vld && !full;
    assign do_rd    = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end
endmodule

// 5-port XY mesh router: input FIFOs, per-output round-robin arbiters, one output register each.
// Latency: 2 cycles from input acceptance to vout.
// Backpressure: rin low stalls the output register; rout drops when that input FIFO is full.
module noc_router #(
    parameter int ADDR_X     = 0,
    parameter int ADDR_Y     = 0,
    parameter int COLS       = 4,
    parameter int ROWS       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5*DATA_WIDTH-1:0] din,
    input  logic [4:0]              vin,
    output logic [4:0]              rout,
    output logic [5*DATA_WIDTH-1:0] dout,
    output logic [4:0]              vout,
    input  logic [4:0]              rin,
    output logic [CNT_W-1:0]        drop_count
);
    localparam int NP = 5;
    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_NORTH = 3'd1;
    localparam logic [2:0] P_EAST  = 3'd2;
    localparam logic [2:0] P_SOUTH = 3'd3;
    localparam logic [2:0] P_WEST  = 3'd4;
    localparam logic [ADDR_W-1:0] MY_X   = ADDR_W'(ADDR_X);
    localparam logic [ADDR_W-1:0] MY_Y   = ADDR_W'(ADDR_Y);
    localparam logic [ADDR_W:0]   COLS_L = (ADDR_W+1)'(COLS);
    localparam logic [ADDR_W:0]   ROWS_L = (ADDR_W+1)'(ROWS);

    logic [DATA_WIDTH-1:0] head [NP];
    logic [2:0]            dir  [NP];
    logic [2:0]            ptr  [NP];
    logic [2:0]            gnt_idx [NP];
    logic [NP-1:0]         gnt_vld;
    logic [NP-1:0]         full;
    logic [NP-1:0]         empty;
    logic [NP-1:0]         oor;
    logic [NP-1:0]         drop;
    logic [NP-1:0]         pop;
    logic [ADDR_W-1:0]     dx;
    logic [ADDR_W-1:0]     dy;
    logic [3:0]            sum;
    logic [2:0]            idx;
    logic                  can_load;
    logic [CNT_W-1:0]      cnt_nxt;

    for (genvar p = 0; p < NP; p++) begin : g_in
        noc_router_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .wr_vld   (vin[p]),
            .wr_dat   (din[p*DATA_WIDTH +: DATA_WIDTH]),
            .rd_en    (pop[p]),
            .full     (full[p]),
            .empty    (empty[p]),
            .head_dat (head[p])
        );
        assign rout[p] = !full[p];
    end

    // Dimension-ordered routing of each head flit: X first, then Y.
    always_comb begin
        dx   = '0;
        dy   = '0;
        oor  = '0;
        drop = '0;
        for (int p = 0; p < NP; p++) begin
            dx = head[p][DATA_WIDTH-1 -: ADDR_W];
            dy = head[p][DATA_WIDTH-ADDR_W-1 -: ADDR_W];
            oor[p]  = ({1'b0, dx} >= COLS_L) || ({1'b0, dy} >= ROWS_L);
            drop[p] = !empty[p] && oor[p];
            if (dx > MY_X)      dir[p] = P_EAST;
            else if (dx < MY_X) dir[p] = P_WEST;
            else if (dy > MY_Y) dir[p] = P_SOUTH;
            else if (dy < MY_Y) dir[p] = P_NORTH;
            else                dir[p] = P_LOCAL;
        end
    end

    // Each input has one route, so it can win at most one arbiter per cycle.
    always_comb begin
        pop      = drop;
        sum      = '0;
        idx      = '0;
        can_load = 1'b0;
        for (int q = 0; q < NP; q++) begin
            gnt_vld[q] = 1'b0;
            gnt_idx[q] = '0;
            can_load   = !vout[q] || rin[q];
            for (int k = 0; k < NP; k++) begin
                sum = {1'b0, ptr[q]} + 4'(k);
                idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
                if (can_load && !gnt_vld[q] && !empty[idx] && !oor[idx] && dir[idx] == 3'(q)) begin
                    gnt_vld[q] = 1'b1;
                    gnt_idx[q] = idx;
                end
            end
            if (gnt_vld[q]) pop[gnt_idx[q]] = 1'b1;
        end
    end

    always_comb begin
        cnt_nxt = drop_count;
        for (int p = 0; p < NP; p++) begin
            if (drop[p] && cnt_nxt != '1) cnt_nxt = cnt_nxt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vout       <= '0;
            dout       <= '0;
            drop_count <= '0;
            for (int q = 0; q < NP; q++) ptr[q] <= '0;
        end else begin
            drop_count <= cnt_nxt;
            for (int q = 0; q < NP; q++) begin
                if (gnt_vld[q]) begin
                    vout[q] <= 1'b1;
                    dout[q*DATA_WIDTH +: DATA_WIDTH] <= head[gnt_idx[q]];
                    ptr[q]  <= (gnt_idx[q] == P_WEST) ? 3'd0 : gnt_idx[q] + 3'd1;
                end else if (rin[q]) begin
                    vout[q] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_noc_router.sv
// Bench for noc_router at mesh position (1,1): directed scenarios plus a randomized
// run scored against per-(input,output) FIFO order queues.
module tb_noc_router;
    localparam int DW = 32;
    localparam int NP = 5;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP*DW-1:0] din;
    logic [NP-1:0]    vin;
    logic [NP-1:0]    rin;
    logic [NP-1:0]    rout;
    logic [NP-1:0]    vout;
    logic [NP*DW-1:0] dout;
    logic [CW-1:0]    drop_count;

    int errors = 0;
    int checks = 0;
    logic [31:0] expq [NP*NP][$];

    noc_router #(
        .ADDR_X(1), .ADDR_Y(1), .COLS(4), .ROWS(4), .DATA_WIDTH(DW),
        .ADDR_W(4), .FIFO_DEPTH(4), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .vin(vin), .rout(rout),
        .dout(dout), .vout(vout), .rin(rin), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // dest x | dest y | 0 | source port | 0 | sequence number
    function automatic logic [31:0] mk(int x, int y, int src, int seq);
        return {4'(x), 4'(y), 1'b0, 3'(src), 4'h0, 16'(seq)};
    endfunction

    function automatic logic [31:0] dq(int q);
        return dout[q*DW +: DW];
    endfunction

    function automatic int route(logic [31:0] f);
        int x;
        int y;
        x = int'(f[31:28]);
        y = int'(f[27:24]);
        if (x > 1) return 2;
        if (x < 1) return 4;
        if (y > 1) return 3;
        if (y < 1) return 1;
        return 0;
    endfunction

    function automatic bit is_oor(logic [31:0] f);
        return (f[31:28] >= 4'd4) || (f[27:24] >= 4'd4);
    endfunction

    task automatic set_in(int p, logic [31:0] f);
        din[p*DW +: DW] = f;
    endtask

    task automatic test_reset;
        rst = 1'b1; vin = '0; rin = '1; din = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (vout !== 5'b0) begin errors++; $display("FAIL reset_vout: got %b want 00000", vout); end
        checks++; if (rout !== 5'b11111) begin errors++; $display("FAIL reset_rout: got %b want 11111", rout); end
        checks++; if (drop_count !== '0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %h want 0", dout); end
    endtask

    task automatic test_single;
        logic [31:0] f;
        f = 32'h2100_0000;
        @(negedge clk);
        rin = '1; set_in(0, f); vin = 5'b00001;
        @(negedge clk);
        vin = '0;
        checks++; if (vout !== 5'b0) begin errors++; $display("FAIL single_early: vout %b want 00000", vout); end
        @(negedge clk);
        checks++; if (vout !== 5'b00100) begin errors++; $display("FAIL single_vout: got %b want 00100", vout); end
        checks++; if (dq(2) !== f) begin errors++; $display("FAIL single_data: got %h want %h", dq(2), f); end
        @(negedge clk);
        checks++; if (vout !== 5'b0) begin errors++; $display("FAIL single_drain: vout %b want 00000", vout); end
    endtask

    task automatic test_arbitration;
        int seq [NP];
        int exp_seq [NP];
        bit acc [NP];
        int cnt [NP];
        logic [2:0] hist [$];
        logic [31:0] f;
        int n_inj;
        int total;
        n_inj = 0;
        for (int p = 0; p < NP; p++) begin
            seq[p] = 0; exp_seq[p] = 0; acc[p] = 1'b0; cnt[p] = 0;
            set_in(p, mk(2, 1, p, 0));
        end
        rin = '1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (c == 36) n_inj = hist.size();
            for (int p = 0; p < NP; p++) begin
                if (acc[p]) begin seq[p]++; set_in(p, mk(2, 1, p, seq[p])); end
            end
            vin = (c < 36) ? 5'b10011 : 5'b00000;
            for (int p = 0; p < NP; p++) acc[p] = vin[p] && rout[p];
            checks++; if ((vout & 5'b11011) !== 5'b0) begin errors++; $display("FAIL arb_other_vout: got %b want 00000 on non-east", vout & 5'b11011); end
            if (vout[2] && rin[2]) begin
                f = dq(2);
                hist.push_back(f[22:20]);
                checks++;
                if (int'(f[15:0]) !== exp_seq[f[22:20]]) begin
                    errors++; $display("FAIL arb_order: src %0d seq %0d want %0d", f[22:20], f[15:0], exp_seq[f[22:20]]);
                end
                exp_seq[f[22:20]]++;
            end
        end
        for (int i = 0; i + 2 < n_inj; i++) begin
            checks++;
            if (hist[i] == hist[i+1] || hist[i] == hist[i+2] || hist[i+1] == hist[i+2]) begin
                errors++; $display("FAIL arb_rotate: grants %0d,%0d,%0d at %0d want three distinct", hist[i], hist[i+1], hist[i+2], i);
            end
        end
        for (int i = 0; i < n_inj; i++) cnt[hist[i]]++;
        checks++; if (n_inj < 30) begin errors++; $display("FAIL arb_throughput: got %0d grants want >=30", n_inj); end
        for (int p = 0; p < NP; p++) begin
            if (p == 0 || p == 1 || p == 4) begin
                checks++;
                if (cnt[p] < n_inj / 3 - 1) begin errors++; $display("FAIL arb_share: src %0d got %0d of %0d want >=%0d", p, cnt[p], n_inj, n_inj / 3 - 1); end
            end
        end
        total = seq[0] + seq[1] + seq[4];
        checks++; if (hist.size() !== total) begin errors++; $display("FAIL arb_lost: delivered %0d want %0d", hist.size(), total); end
    endtask

    task automatic test_backpressure;
        logic [31:0] fl [6];
        int sent;
        int nout;
        bit acc;
        sent = 0; nout = 0; acc = 1'b0;
        for (int k = 0; k < 6; k++) fl[k] = mk(2, 1, 0, 100 + k);
        rin = 5'b11011; vin = '0;
        for (int c = 0; c < 40 && nout < 6; c++) begin
            @(negedge clk);
            if (acc) sent++;
            set_in(0, fl[(sent < 6) ? sent : 5]);
            vin = (sent < 6) ? 5'b00001 : 5'b00000;
            if (c == 10) begin
                checks++; if (sent !== 5) begin errors++; $display("FAIL bp_accepted: got %0d want 5", sent); end
                checks++; if (rout[0] !== 1'b0) begin errors++; $display("FAIL bp_rout: got %b want 0", rout[0]); end
                checks++; if (vout !== 5'b00100) begin errors++; $display("FAIL bp_vout_hold: got %b want 00100", vout); end
                checks++; if (dq(2) !== fl[0]) begin errors++; $display("FAIL bp_dout_hold: got %h want %h", dq(2), fl[0]); end
                rin = '1;
            end
            acc = vin[0] && rout[0];
            if (vout[2] && rin[2]) begin
                checks++; if (dq(2) !== fl[nout]) begin errors++; $display("FAIL bp_order: got %h want %h", dq(2), fl[nout]); end
                nout++;
            end
        end
        checks++; if (nout !== 6) begin errors++; $display("FAIL bp_count: delivered %0d want 6", nout); end
    endtask

    task automatic test_drop;
        logic [31:0] pat [3];
        int sent;
        int lim;
        int want;
        bit acc;
        pat[0] = mk(7, 0, 0, 0); pat[1] = mk(1, 5, 0, 0); pat[2] = mk(4, 4, 0, 0);
        sent = 0; acc = 1'b0; rin = '1; vin = '0;
        for (int ph = 0; ph < 3; ph++) begin
            lim  = (ph == 0) ? 1 : (ph == 1) ? 15 : 16;
            want = (ph == 0) ? 1 : 15;
            for (int c = 0; c < 2 * lim + 4; c++) begin
                @(negedge clk);
                if (acc) sent++;
                set_in(0, pat[sent % 3]);
                vin = (sent < lim) ? 5'b00001 : 5'b00000;
                acc = vin[0] && rout[0];
                checks++; if (vout !== 5'b0) begin errors++; $display("FAIL drop_vout: got %b want 00000", vout); end
            end
            checks++; if (int'(drop_count) !== want) begin errors++; $display("FAIL drop_count_%0d: got %0d want %0d", ph, drop_count, want); end
        end
    endtask

    task automatic test_parallel;
        logic [31:0] fn;
        logic [31:0] fw;
        fn = mk(1, 2, 1, 7);
        fw = mk(2, 1, 4, 8);
        @(negedge clk);
        rin = '1; set_in(1, fn); set_in(4, fw); vin = 5'b10010;
        @(negedge clk);
        vin = '0;
        checks++; if (vout !== 5'b0) begin errors++; $display("FAIL par_early: vout %b want 00000", vout); end
        @(negedge clk);
        checks++; if (vout !== 5'b01100) begin errors++; $display("FAIL par_vout: got %b want 01100", vout); end
        checks++; if (dq(3) !== fn) begin errors++; $display("FAIL par_south: got %h want %h", dq(3), fn); end
        checks++; if (dq(2) !== fw) begin errors++; $display("FAIL par_east: got %h want %h", dq(2), fw); end
    endtask

    task automatic test_reset_mid;
        int sent;
        bit acc;
        sent = 0; acc = 1'b0; rin = '0; vin = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (acc) sent++;
            set_in(0, mk(2, 1, 0, 200 + sent));
            vin = (sent < 3) ? 5'b00001 : 5'b00000;
            acc = vin[0] && rout[0];
        end
        @(negedge clk);
        rst = 1'b1;
        for (int p = 0; p < NP; p++) set_in(p, mk(1, 1, p, 300));
        vin = 5'b11111;
        @(negedge clk);
        rst = 1'b0; vin = '0; rin = '1;
        checks++; if (vout !== 5'b0) begin errors++; $display("FAIL rstmid_vout: got %b want 00000", vout); end
        checks++; if (rout !== 5'b11111) begin errors++; $display("FAIL rstmid_rout: got %b want 11111", rout); end
        checks++; if (drop_count !== '0) begin errors++; $display("FAIL rstmid_drop: got %0d want 0", drop_count); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++; if (vout !== 5'b0) begin errors++; $display("FAIL rstmid_stale: vout %b want 00000", vout); end
        end
    endtask

    task automatic test_random;
        logic [31:0] cur [NP];
        logic [31:0] prev_d [NP];
        bit has [NP];
        bit acc [NP];
        bit stall [NP];
        logic [31:0] f;
        int seq;
        int exp_drops;
        int x;
        int y;
        int s;
        int left;
        seq = 0; exp_drops = 0;
        for (int p = 0; p < NP; p++) begin has[p] = 0; acc[p] = 0; stall[p] = 0; cur[p] = '0; prev_d[p] = '0; end
        for (int i = 0; i < NP * NP; i++) expq[i].delete();
        for (int c = 0; c < 360; c++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (acc[p]) has[p] = 1'b0;
                if (!has[p] && c < 300 && $urandom_range(1, 0) == 1) begin
                    x = ($urandom_range(63, 0) == 0) ? 9 : int'($urandom_range(3, 0));
                    y = ($urandom_range(63, 0) == 0) ? 6 : int'($urandom_range(3, 0));
                    cur[p] = mk(x, y, p, seq);
                    seq++;
                    has[p] = 1'b1;
                end
                set_in(p, cur[p]);
                vin[p] = has[p];
                rin[p] = (c >= 300) || ($urandom_range(3, 0) != 0);
            end
            for (int p = 0; p < NP; p++) begin
                acc[p] = vin[p] && rout[p];
                if (acc[p]) begin
                    if (is_oor(cur[p])) exp_drops++;
                    else expq[p*NP + route(cur[p])].push_back(cur[p]);
                end
            end
            for (int q = 0; q < NP; q++) begin
                if (stall[q]) begin
                    checks++;
                    if (vout[q] !== 1'b1 || dq(q) !== prev_d[q]) begin
                        errors++; $display("FAIL rnd_hold: port %0d vout %b dout %h want 1 %h", q, vout[q], dq(q), prev_d[q]);
                    end
                end
                if (vout[q] && rin[q]) begin
                    f = dq(q);
                    s = int'(f[22:20]);
                    checks++;
                    if (s >= NP) begin
                        errors++; $display("FAIL rnd_src: port %0d flit %h has bad source", q, f);
                    end else if (expq[s*NP + q].size() == 0) begin
                        errors++; $display("FAIL rnd_unexpected: port %0d got %h want nothing from src %0d", q, f, s);
                    end else if (expq[s*NP + q][0] !== f) begin
                        errors++; $display("FAIL rnd_data: port %0d got %h want %h", q, f, expq[s*NP + q][0]);
                        void'(expq[s*NP + q].pop_front());
                    end else begin
                        void'(expq[s*NP + q].pop_front());
                    end
                end
                stall[q] = vout[q] && !rin[q];
                prev_d[q] = dq(q);
            end
        end
        left = 0;
        for (int i = 0; i < NP * NP; i++) left += expq[i].size();
        checks++; if (left !== 0) begin errors++; $display("FAIL rnd_undelivered: got %0d flits left want 0", left); end
        checks++;
        if (int'(drop_count) !== ((exp_drops > 15) ? 15 : exp_drops)) begin
            errors++; $display("FAIL rnd_drops: got %0d want %0d", drop_count, (exp_drops > 15) ? 15 : exp_drops);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_arbitration;
        test_backpressure;
        test_drop;
        test_parallel;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
